// File: rtl/light_cmd_scheduler.sv
// light_cmd_scheduler: round-robin scheduler sharing one LightingSystem (req/mode_bus/ulight_bus/lenght_bus in; ack/err/busy and tcode/ulight/lenght out; wshade/lightnum/lightstate captured into res_*); `define LSCHED_AUTOOFF_EN to enable idle auto-off
module light_cmd_scheduler #(
  parameter int NREQ = 4,
  parameter int ID_W = 3,
  parameter int HOLD_CYC = 2,
  parameter int IDLE_TO = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] mode_bus,
  input  logic [4*NREQ-1:0] ulight_bus,
  input  logic [4*NREQ-1:0] lenght_bus,
  output logic [NREQ-1:0]   ack,
  output logic              err,
  output logic              busy,
  output logic [3:0]        tcode,
  output logic [3:0]        ulight,
  output logic [3:0]        lenght,
  input  logic [3:0]        wshade,
  input  logic [3:0]        lightnum,
  input  logic [15:0]       lightstate,
  output logic              res_valid,
  output logic [ID_W-1:0]   res_id,
  output logic              res_auto,
  output logic [15:0]       res_state,
  output logic [3:0]        res_num,
  output logic [3:0]        res_shade
);
  localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state, state_nx;
  logic [PW-1:0] ptr, gsel;
  logic found, gvalid, auto_go;
  logic [3:0] gmode, cnt;
  logic [ID_W-1:0] gid;
  always_comb begin
    int j;
    found = 1'b0;
    gsel = ptr;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!found && req[j]) begin
        found = 1'b1;
        gsel = PW'(j);
      end
    end
  end
  assign gmode = mode_bus[{gsel, 2'b00} +: 4];
  assign gvalid = (gmode != 4'd0) && ((gmode & (gmode - 4'd1)) == 4'd0);
`ifdef LSCHED_AUTOOFF_EN
  localparam int IW = $clog2(IDLE_TO + 1);
  logic [IW-1:0] idle_cnt;
  assign auto_go = (state == IDLE) && !found && (idle_cnt == IW'(IDLE_TO - 1));
  always_ff @(posedge clk)
    idle_cnt <= (rst || state != IDLE || found || auto_go) ? '0 : idle_cnt + IW'(1);
  always_ff @(posedge clk)
    res_auto <= rst ? 1'b0 : (state == ISSUE && cnt == 4'd0) ? (gid == ID_W'(NREQ)) : res_auto;
`else
  assign auto_go = 1'b0;
  assign res_auto = 1'b0;
`endif
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = (state == IDLE) ? (((found && gvalid) || auto_go) ? ISSUE : IDLE)
                               : ((cnt == 4'd0) ? IDLE : ISSUE);
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= PW'(NREQ - 1);
      ack <= '0;
      err <= 1'b0;
      busy <= 1'b0;
      tcode <= '0;
      ulight <= '0;
      lenght <= '0;
      cnt <= '0;
      gid <= '0;
      res_valid <= 1'b0;
      res_id <= '0;
      res_state <= '0;
      res_num <= '0;
      res_shade <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      res_valid <= 1'b0;
      if (state == IDLE && found) begin
        ack <= NREQ'(1) << gsel;
        ptr <= gsel;
        err <= !gvalid;
        if (gvalid) begin
          tcode <= gmode;
          ulight <= ulight_bus[{gsel, 2'b00} +: 4];
          lenght <= lenght_bus[{gsel, 2'b00} +: 4];
          busy <= 1'b1;
          cnt <= 4'(HOLD_CYC - 1);
          gid <= ID_W'(gsel);
        end
      end else if (auto_go) begin
        tcode <= 4'b0001;
        ulight <= '0;
        lenght <= '0;
        busy <= 1'b1;
        cnt <= 4'(HOLD_CYC - 1);
        gid <= ID_W'(NREQ);
      end else if (state == ISSUE) begin
        if (cnt == 4'd0) begin
          res_valid <= 1'b1;
          res_id <= gid;
          res_state <= lightstate;
          res_num <= lightnum;
          res_shade <= wshade;
          tcode <= '0;
          ulight <= '0;
          lenght <= '0;
          busy <= 1'b0;
        end else begin
          cnt <= cnt - 4'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_light_cmd_scheduler.sv
// tb_light_cmd_scheduler: scoreboard bench for light_cmd_scheduler against a transaction-level reference model
module tb_light_cmd_scheduler;
  localparam int NREQ = 4, ID_W = 3, HOLD = 2, ITO = 8;
`ifdef LSCHED_AUTOOFF_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req = '0, ack;
  logic [4*NREQ-1:0] mode_bus = '0, ulight_bus = '0, lenght_bus = '0;
  logic err, busy, res_valid, res_auto;
  logic [3:0] tcode, ulight, lenght, wshade = '0, lightnum = '0, res_num, res_shade;
  logic [15:0] lightstate = '0, res_state;
  logic [ID_W-1:0] res_id;
  light_cmd_scheduler #(.NREQ(NREQ), .ID_W(ID_W), .HOLD_CYC(HOLD), .IDLE_TO(ITO)) dut (
    .clk(clk), .rst(rst), .req(req), .mode_bus(mode_bus), .ulight_bus(ulight_bus),
    .lenght_bus(lenght_bus), .ack(ack), .err(err), .busy(busy), .tcode(tcode),
    .ulight(ulight), .lenght(lenght), .wshade(wshade), .lightnum(lightnum),
    .lightstate(lightstate), .res_valid(res_valid), .res_id(res_id), .res_auto(res_auto),
    .res_state(res_state), .res_num(res_num), .res_shade(res_shade));
  always #5 clk = ~clk;
  typedef struct {int idx; bit e;} ack_t;
  typedef struct {int id; bit a; logic [15:0] st; logic [3:0] num; logic [3:0] sh;} res_t;
  ack_t qa[$];
  res_t qr[$];
  int glog[$];
  int passed = 0, total = 0;
  int drv_mode = 0, req_prob = 4;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask
  // reference model: a command occupies the datapath for HOLD edges after its grant edge
  int m_ptr, m_hold, m_idle, m_id, g;
  bit m_auto;
  logic [11:0] m_cmd;
  logic [3:0] m;
  res_t m_last, r;
  always @(posedge clk) begin
    if (rst) begin
      m_ptr = NREQ - 1; m_hold = 0; m_idle = 0; m_cmd = '0; m_id = 0; m_auto = 0;
      m_last = '{0, 1'b0, 16'h0, 4'h0, 4'h0};
      qa.delete(); qr.delete();
    end else if (m_hold > 0) begin
      m_hold--;
      m_idle = 0;
      if (m_hold == 0) begin
        r = '{m_id, m_auto, lightstate, lightnum, wshade};
        qr.push_back(r);
        m_last = r;
        m_cmd = '0;
      end
    end else if (req != '0) begin
      g = -1;
      for (int k = 1; k <= NREQ; k++)
        if (g < 0 && req[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      m = mode_bus[4*g +: 4];
      qa.push_back('{g, $countones(m) != 1});
      m_ptr = g;
      m_idle = 0;
      if ($countones(m) == 1) begin
        m_hold = HOLD; m_id = g; m_auto = 0;
        m_cmd = {m, ulight_bus[4*g +: 4], lenght_bus[4*g +: 4]};
      end
    end else if (AUTO) begin
      m_idle++;
      if (m_idle == ITO) begin
        m_idle = 0; m_hold = HOLD; m_id = NREQ; m_auto = 1; m_cmd = 12'h100;
      end
    end
  end
  always @(negedge clk) begin
    ack_t ea;
    res_t er;
    if (ack != '0 || err) begin
      for (int i = 0; i < NREQ; i++) if (ack[i]) glog.push_back(i);
      if (qa.size() == 0) begin
        total++;
        $display("FAIL ack_unexpected: got ack=%b err=%b expected no grant", ack, err);
      end else begin
        ea = qa.pop_front();
        chk("ack", 64'(ack), 64'(1 << ea.idx));
        chk("err", 64'(err), 64'(ea.e));
      end
    end else if (qa.size() > 0) begin
      total++;
      ea = qa.pop_front();
      $display("FAIL ack_missing: got ack=0 expected ack index %0d", ea.idx);
    end
    if (res_valid) begin
      if (qr.size() == 0) begin
        total++;
        $display("FAIL res_unexpected: got res_valid=1 expected 0");
      end else begin
        er = qr.pop_front();
        chk("res", {res_id, res_auto, res_state, res_num, res_shade},
            {3'(er.id), er.a, er.st, er.num, er.sh});
      end
    end else if (qr.size() > 0) begin
      total++;
      er = qr.pop_front();
      $display("FAIL res_missing: got res_valid=0 expected result id %0d", er.id);
    end
    chk("cmd", {busy, tcode, ulight, lenght}, {m_hold > 0, m_cmd});
    chk("res_hold", {res_id, res_auto, res_state, res_num, res_shade},
        {3'(m_last.id), m_last.a, m_last.st, m_last.num, m_last.sh});
  end
  task automatic newf(input int i);
    int s = $urandom % 8;
    mode_bus[4*i +: 4] = s < 6 ? 4'(1 << ($urandom % 4)) : s == 6 ? 4'b0000 : (4'($urandom) | 4'b0011);
    ulight_bus[4*i +: 4] = 4'($urandom);
    lenght_bus[4*i +: 4] = 4'($urandom);
  endtask
  // drv_mode 0: drop req on ack, 1: keep req high, 2: random traffic
  task automatic step();
    @(negedge clk);
    lightstate = 16'($urandom);
    lightnum = 4'($urandom);
    wshade = 4'($urandom);
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i] && drv_mode == 0) req[i] = 1'b0;
      else if (ack[i] && drv_mode == 2) begin
        if ($urandom % 4 == 0) newf(i);
        else req[i] = 1'b0;
      end else if (drv_mode == 2 && !req[i] && $urandom % req_prob == 0) begin
        newf(i);
        req[i] = 1'b1;
      end
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask
  initial begin
    repeat (2) step();
    chk("reset_outputs", {ack, err, busy, tcode, ulight, lenght, res_valid, res_id, res_auto, res_state, res_num, res_shade}, 64'd0);
    rst = 1'b0;
    mode_bus[3:0] = 4'b0001; ulight_bus[3:0] = 4'b0101; lenght_bus[3:0] = 4'b0011;
    req = 4'b0001;
    repeat (8) step();
    do_reset();
    mode_bus = 16'h8421; ulight_bus = 16'h1234; lenght_bus = 16'hfedc;
    glog.delete();
    drv_mode = 1;
    req = 4'b1111;
    repeat (18) step();
    req = '0;
    drv_mode = 0;
    repeat (4) step();
    if (glog.size() < 5) begin
      total++;
      $display("FAIL rr_order: got %0d grants expected at least 5", glog.size());
    end else
      for (int i = 0; i < 5; i++) chk("rr_order", 64'(glog[i]), 64'(i % 4));
    mode_bus[7:4] = 4'b0000; req = 4'b0010;
    repeat (4) step();
    mode_bus[7:4] = 4'b0110; req = 4'b0010;
    repeat (4) step();
    mode_bus[3:0] = 4'b0100; req = 4'b0001;
    for (int k = 0; k < 10 && !ack[0]; k++) step();
    if (!ack[0]) begin
      total++;
      $display("FAIL rst_issue_wait: got no ack within 10 cycles expected ack[0]");
    end
    rst = 1'b1;
    step();
    chk("rst_mid_issue", {tcode, busy, res_valid}, 6'd0);
    glog.delete();
    drv_mode = 1;
    req = 4'b1111;
    rst = 1'b0;
    repeat (3) step();
    if (glog.size() == 0) begin
      total++;
      $display("FAIL first_after_rst: got no grant expected source 0");
    end else chk("first_after_rst", 64'(glog[0]), 64'd0);
    req = '0;
    drv_mode = 0;
    repeat (4) step();
`ifdef LSCHED_AUTOOFF_EN
    do_reset();
    glog.delete();
    repeat (ITO + 4) step();
    chk("auto_no_ack", 64'(glog.size()), 64'd0);
    chk("auto_res", {res_id, res_auto}, {3'(NREQ), 1'b1});
    do_reset();
    repeat (ITO - 1) step();
    mode_bus[11:8] = 4'b0010;
    req = 4'b0100;
    repeat (6) step();
    chk("expiry_grant", {res_id, res_auto}, {3'd2, 1'b0});
`endif
    drv_mode = 2;
    for (int n = 0; n < 3000; n++) begin
      req_prob = 1 + (n / 500) * 3;
      rst = ($urandom % 150 == 0);
      step();
    end
    rst = 1'b0;
    drv_mode = 0;
    req = '0;
    repeat (3 * ITO) step();
    chk("drain", 64'(qa.size() + qr.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
